sum_accumulator: RTL and testbench



---
 rtl/sum_accumulator.sv | 111 +++++++++++
 tb/tb_sum_accumulator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Accumulates a programmed number of adder S/Cout results into a running total with a sticky overflow flag.
// Optional macro SUM_ACCUMULATOR_SATURATE_EN: clamp the total to all-ones once overflow is seen.
module sum_accumulator #(
    parameter int WIDTH   = 64,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_S,
    input  logic               in_Cout,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_carry,
    output logic [COUNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;

    logic [WIDTH:0]     sum_w;
    logic               carry_next_w;

`ifdef SUM_ACCUMULATOR_SATURATE_EN
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] sum,
                                                  input logic             ovf);
        return ovf ? {WIDTH{1'b1}} : sum;
    endfunction
`endif

    assign sum_w        = {1'b0, acc_q} + {1'b0, in_S};
    assign carry_next_w = carry_q | sum_w[WIDTH] | in_Cout;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d       = '0;
                    carry_d     = 1'b0;
                    count_d     = '0;
                    remaining_d = len;
                    state_d     = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
`ifdef SUM_ACCUMULATOR_SATURATE_EN
                    acc_d = saturate(sum_w[WIDTH-1:0], carry_next_w);
`else
                    acc_d = sum_w[WIDTH-1:0];
`endif
                    carry_d     = carry_next_w;
                    count_d     = count_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == COUNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_carry = carry_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: directed sequences push expected results, a monitor checks each handshake.
module tb_sum_accumulator;
    localparam int WIDTH   = 64;
    localparam int COUNT_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [COUNT_W-1:0] len;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_S;
    logic               in_Cout;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_sum;
    logic               out_carry;
    logic [COUNT_W-1:0] out_count;

    sum_accumulator #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_S(in_S), .in_Cout(in_Cout),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0]   sum;
        logic               carry;
        logic [COUNT_W-1:0] count;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fails  = 0;

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel 0 waits for in_ready, sel 1 for out_valid
    task automatic wait_sig(input int sel, input string name);
        int n = 0;
        while (((sel == 0) ? in_ready : out_valid) !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fails++;
            $display("FAIL timeout_%s: still low after %0d cycles, expected high", name, n);
        end
    endtask

    task automatic expect_result(input logic [WIDTH-1:0] s, input logic c, input logic [COUNT_W-1:0] n);
        exp_t e;
        e.sum = s; e.carry = c; e.count = n;
        exp_q.push_back(e);
    endtask

    task automatic start_seq(input logic [COUNT_W-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = 8'hFF;
    endtask

    task automatic send(input logic [WIDTH-1:0] s, input logic c);
        in_S     = s;
        in_Cout  = c;
        in_valid = 1'b1;
        wait_sig(0, "in_ready");
        tick();
        in_valid = 1'b0;
        in_S     = '0;
        in_Cout  = 1'b0;
    endtask

    task automatic collect(input int hold);
        out_ready = 1'b0;
        wait_sig(1, "out_valid");
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            if (exp_q.size() > 0) check("hold_sum", out_sum, exp_q[0].sum);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_out_valid", out_valid, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_result: sum %h with no expected entry", out_sum);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_sum", out_sum, mon_e.sum);
                check("out_carry", out_carry, mon_e.carry);
                check("out_count", out_count, mon_e.count);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_S = '0; in_Cout = 1'b0; out_ready = 1'b0;
        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_count", out_count, 0);
        rst = 1'b0;
        tick();

        // in_valid while idle must be ignored
        in_valid = 1'b1; in_S = 64'hDEAD;
        tick(); tick();
        check("idle_in_ready", in_ready, 0);
        check("idle_busy_invalid", busy, 0);
        in_valid = 1'b0; in_S = '0;

        // reset mid-sequence
        start_seq(4);
        check("accum_busy", busy, 1);
        check("accum_in_ready", in_ready, 1);
        send(64'h7, 1'b0);
        send(64'h9, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_sum", out_sum, 0);
        check("midrst_out_carry", out_carry, 0);
        check("midrst_out_count", out_count, 0);
        #3 rst = 1'b0;
        tick();

        // basic back-to-back
        expect_result(64'h25, 1'b0, 3);
        start_seq(3);
        send(64'hA, 1'b0);
        send(64'hA, 1'b0);
        check("latency_before_last", out_valid, 0);
        send(64'h11, 1'b0);
        check("latency_valid", out_valid, 1);
        check("done_in_ready", in_ready, 0);
        collect(0);

        // backpressure on both sides
        expect_result(64'h25, 1'b0, 3);
        start_seq(3);
        send(64'hA, 1'b0); tick();
        send(64'hA, 1'b0); tick();
        send(64'h11, 1'b0);
        collect(5);

        // overflow
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        expect_result(ONES, 1'b1, 2);
`else
        expect_result(64'h1, 1'b1, 2);
`endif
        start_seq(2);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'h2, 1'b0);
        collect(0);

        // upstream carry
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        expect_result(ONES, 1'b1, 1);
`else
        expect_result(64'h5, 1'b1, 1);
`endif
        start_seq(1);
        send(64'h5, 1'b1);
        collect(0);

        // len = 0 goes straight to DONE
        expect_result(64'h0, 1'b0, 0);
        start_seq(0);
        check("len0_valid", out_valid, 1);
        check("len0_in_ready", in_ready, 0);
        collect(0);

        // start during ACCUM is ignored
        expect_result(64'h123, 1'b0, 2);
        start_seq(2);
        send(64'h100, 1'b0);
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        check("ign_start_busy", busy, 1);
        check("ign_start_count", out_count, 1);
        send(64'h23, 1'b0);
        check("ign_start_done", out_valid, 1);
        collect(0);

        tick(); tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
